// File: rtl/pll_reconfig_ctrl_if.sv
// Host-side request/response bundle for the PLL reconfiguration controller.
interface pll_reconfig_ctrl_if;
    logic       wr_req;
    logic       rd_req;
    logic [8:0] cfg_m;
    logic [8:0] cfg_n;
    logic       busy;
    logic       done;
    logic       error;
    logic [8:0] rd_m;
    logic [8:0] rd_n;

    modport master (
        output wr_req, rd_req, cfg_m, cfg_n,
        input  busy, done, error, rd_m, rd_n
    );

    modport slave (
        input  wr_req, rd_req, cfg_m, cfg_n,
        output busy, done, error, rd_m, rd_n
    );
endinterface

// File: rtl/pll_reconfig_ctrl.sv
// PLL scan-chain reconfiguration controller: serial write of {M,N}, update strobe,
// scandone/locked handshake with timeouts, and serial readback of the chain.
module pll_reconfig_ctrl #(
    parameter int unsigned SCAN_LEN = 18,  // must be >= 18; {M,N} occupy the top of the chain
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic               inclk0,
    input  logic               areset_n,
    pll_reconfig_ctrl_if.slave host,
    output logic               scanclk,
    output logic               scandata,
    output logic               scanwrite,
    output logic               scanread,
    output logic               scanclkena,
    output logic               configupdate,
    output logic               scanaclr,
    input  logic               scandataout,
    input  logic               scandone,
    input  logic               locked
);

    localparam int unsigned DivW = $clog2(CLK_DIV + 1);
    localparam int unsigned BitW = $clog2(SCAN_LEN + 1);
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
    localparam int unsigned PadBits = SCAN_LEN - 18;

    typedef enum logic [2:0] {
        StIdle,
        StShiftWr,
        StUpdate,
        StWaitDone,
        StWaitLock,
        StShiftRd
    } state_e;

    state_e              state_q;
    logic [DivW-1:0]     div_cnt_q;
    logic [BitW-1:0]     bit_cnt_q;
    logic [TmoW-1:0]     tmo_cnt_q;
    logic [SCAN_LEN-1:0] sr_q;
    logic                aclr_hold_q;

    logic div_tick;
    logic clk_rise;
    logic clk_fall;
    logic last_bit;
    logic tmo_hit;

    assign div_tick = (div_cnt_q == DivW'(CLK_DIV - 1));
    assign clk_rise = div_tick & ~scanclk;
    assign clk_fall = div_tick & scanclk;
    assign last_bit = (bit_cnt_q == BitW'(SCAN_LEN - 1));
    assign tmo_hit  = (tmo_cnt_q == TmoW'(TIMEOUT - 1));

    assign scanclkena = scanwrite | scanread;
    assign scandata   = scanwrite & sr_q[SCAN_LEN-1];

    always_ff @(posedge inclk0 or negedge areset_n) begin
        if (!areset_n) begin
            state_q      <= StIdle;
            div_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            sr_q         <= '0;
            aclr_hold_q  <= 1'b1;
            scanaclr     <= 1'b1;
            scanclk      <= 1'b0;
            scanwrite    <= 1'b0;
            scanread     <= 1'b0;
            configupdate <= 1'b0;
            host.busy    <= 1'b0;
            host.done    <= 1'b0;
            host.error   <= 1'b0;
            host.rd_m    <= '0;
            host.rd_n    <= '0;
        end else begin
            // Two-stage release keeps scanaclr high through the first full cycle after reset.
            aclr_hold_q  <= 1'b0;
            scanaclr     <= aclr_hold_q;
            host.done    <= 1'b0;
            configupdate <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    div_cnt_q <= '0;
                    bit_cnt_q <= '0;
                    scanclk   <= 1'b0;
                    if (host.wr_req) begin
                        state_q   <= StShiftWr;
                        sr_q      <= SCAN_LEN'({host.cfg_m, host.cfg_n}) << PadBits;
                        host.busy <= 1'b1;
                        scanwrite <= 1'b1;
                    end else if (host.rd_req) begin
                        state_q   <= StShiftRd;
                        sr_q      <= '0;
                        host.busy <= 1'b1;
                        scanread  <= 1'b1;
                    end
                end

                StShiftWr, StShiftRd: begin
                    if (div_tick) begin
                        div_cnt_q <= '0;
                        scanclk   <= ~scanclk;
                    end else begin
                        div_cnt_q <= div_cnt_q + DivW'(1);
                    end
                    // Readback captures on the rising edge; write data moves on the falling edge.
                    if (clk_rise && state_q == StShiftRd) begin
                        sr_q <= {sr_q[SCAN_LEN-2:0], scandataout};
                    end
                    if (clk_fall) begin
                        bit_cnt_q <= bit_cnt_q + BitW'(1);
                        if (state_q == StShiftWr) begin
                            sr_q <= {sr_q[SCAN_LEN-2:0], 1'b0};
                        end
                        if (last_bit) begin
                            bit_cnt_q <= '0;
                            if (state_q == StShiftWr) begin
                                state_q      <= StUpdate;
                                scanwrite    <= 1'b0;
                                configupdate <= 1'b1;
                            end else begin
                                state_q    <= StIdle;
                                scanread   <= 1'b0;
                                host.busy  <= 1'b0;
                                host.done  <= 1'b1;
                                host.error <= 1'b0;
                                host.rd_m  <= sr_q[17:9];
                                host.rd_n  <= sr_q[8:0];
                            end
                        end
                    end
                end

                StUpdate: begin
                    state_q   <= StWaitDone;
                    tmo_cnt_q <= '0;
                end

                StWaitDone: begin
                    if (scandone) begin
                        state_q   <= StWaitLock;
                        tmo_cnt_q <= '0;
                    end else if (tmo_hit) begin
                        state_q    <= StIdle;
                        host.busy  <= 1'b0;
                        host.done  <= 1'b1;
                        host.error <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
                    end
                end

                StWaitLock: begin
                    if (locked || tmo_hit) begin
                        state_q    <= StIdle;
                        host.busy  <= 1'b0;
                        host.done  <= 1'b1;
                        host.error <= ~locked;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
                    end
                end

                default: begin
                    state_q   <= StIdle;
                    host.busy <= 1'b0;
                    scanclk   <= 1'b0;
                    scanwrite <= 1'b0;
                    scanread  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed self-checking bench for pll_reconfig_ctrl at default parameters.
module tb_pll_reconfig_ctrl;

    localparam int TIMEOUT      = 1024;
    localparam int SHIFT_CYCLES = 18 * 2 * 2;

    logic inclk0      = 1'b0;
    logic areset_n    = 1'b1;
    logic scandataout = 1'b0;
    logic scandone    = 1'b0;
    logic locked      = 1'b0;
    logic scanclk, scandata, scanwrite, scanread, scanclkena, configupdate, scanaclr;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_rd_m = '0;
    logic [8:0] exp_rd_n = '0;

    pll_reconfig_ctrl_if host_if ();

    pll_reconfig_ctrl dut (
        .inclk0       (inclk0),
        .areset_n     (areset_n),
        .host         (host_if),
        .scanclk      (scanclk),
        .scandata     (scandata),
        .scanwrite    (scanwrite),
        .scanread     (scanread),
        .scanclkena   (scanclkena),
        .configupdate (configupdate),
        .scanaclr     (scanaclr),
        .scandataout  (scandataout),
        .scandone     (scandone),
        .locked       (locked)
    );

    always #5 inclk0 = ~inclk0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge inclk0);
        #1;
    endtask

    task automatic wait_done(input int budget, output int t);
        t = 0;
        while (host_if.done !== 1'b1 && t < budget) begin
            tick();
            t++;
        end
    endtask

    // mode 0: normal handshake, 1: scandone never comes, 2: locked never comes
    task automatic do_write(input logic [8:0] m, input logic [8:0] n, input int mode,
                            input logic also_rd, input logic poke);
        logic [17:0] got;
        logic        prev_clk, saw_rd;
        int          wr_cycles, dones, t;
        got = '0; prev_clk = 1'b0; saw_rd = 1'b0; wr_cycles = 0; dones = 0;
        host_if.cfg_m  = m;
        host_if.cfg_n  = n;
        host_if.wr_req = 1'b1;
        host_if.rd_req = also_rd;
        tick();
        host_if.wr_req = 1'b0;
        host_if.rd_req = 1'b0;
        check_eq("wr_busy", host_if.busy, 1'b1);
        check_eq("wr_clkena", scanclkena, 1'b1);
        while (scanwrite === 1'b1 && wr_cycles < 200) begin
            if (scanclk && !prev_clk) got = {got[16:0], scandata};
            prev_clk = scanclk;
            saw_rd |= scanread;
            if (host_if.done === 1'b1) dones++;
            wr_cycles++;
            host_if.wr_req = poke && (wr_cycles == 10);
            host_if.rd_req = poke && (wr_cycles == 10);
            tick();
        end
        host_if.wr_req = 1'b0;
        host_if.rd_req = 1'b0;
        check_eq("wr_len", wr_cycles, SHIFT_CYCLES);
        check_eq("wr_bits", got, {m, n});
        check_eq("wr_no_read", saw_rd, 1'b0);
        check_eq("wr_clk_exit", scanclk, 1'b0);
        check_eq("cfgupd_on", configupdate, 1'b1);
        tick();
        check_eq("cfgupd_off", configupdate, 1'b0);
        if (mode == 0) begin
            repeat (4) tick();
            scandone = 1'b1;
            repeat (10) tick();
            locked = 1'b1;
            wait_done(20, t);
            check_eq("lock_latency", t, 1);
        end else if (mode == 1) begin
            wait_done(TIMEOUT + 10, t);
            check_eq("tmo_done_cycles", t, TIMEOUT);
        end else begin
            repeat (4) tick();
            scandone = 1'b1;
            tick();
            wait_done(TIMEOUT + 10, t);
            check_eq("tmo_lock_cycles", t, TIMEOUT);
        end
        check_eq("wr_done", host_if.done, 1'b1);
        check_eq("wr_error", host_if.error, mode != 0);
        scandone = 1'b0;
        locked   = 1'b0;
        tick();
        check_eq("wr_done_pulse", host_if.done, 1'b0);
        check_eq("wr_error_hold", host_if.error, mode != 0);
        check_eq("wr_idle", host_if.busy, 1'b0);
        repeat (10) begin
            if (host_if.done === 1'b1) dones++;
            tick();
        end
        check_eq("wr_extra_dones", dones, 0);
        check_eq("wr_rd_m_kept", host_if.rd_m, exp_rd_m);
        check_eq("wr_rd_n_kept", host_if.rd_n, exp_rd_n);
    endtask

    task automatic do_read(input logic [8:0] m, input logic [8:0] n);
        logic [17:0] word;
        logic        prev_clk, saw_wr;
        int          k, t;
        word = {m, n}; prev_clk = 1'b0; saw_wr = 1'b0; k = 0; t = 0;
        host_if.rd_req = 1'b1;
        tick();
        host_if.rd_req = 1'b0;
        while (scanread === 1'b1 && t < 200) begin
            saw_wr |= scanwrite;
            if (scanclk && !prev_clk) k++;
            prev_clk = scanclk;
            scandataout = (k < 18) ? word[17-k] : 1'b0;
            tick();
            t++;
        end
        scandataout = 1'b0;
        check_eq("rd_len", t, SHIFT_CYCLES);
        check_eq("rd_bits", k, 18);
        check_eq("rd_done", host_if.done, 1'b1);
        check_eq("rd_error", host_if.error, 1'b0);
        check_eq("rd_m", host_if.rd_m, m);
        check_eq("rd_n", host_if.rd_n, n);
        check_eq("rd_no_write", saw_wr, 1'b0);
        check_eq("rd_clk_exit", scanclk, 1'b0);
        exp_rd_m = m;
        exp_rd_n = n;
        tick();
        check_eq("rd_done_pulse", host_if.done, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   falls;
        logic prev_clk;
        host_if.wr_req = 1'b0;
        host_if.rd_req = 1'b0;
        host_if.cfg_m  = '0;
        host_if.cfg_n  = '0;

        #2 areset_n = 1'b0;
        #1;
        check_eq("rst_busy", host_if.busy, 1'b0);
        check_eq("rst_done", host_if.done, 1'b0);
        check_eq("rst_outs", {scanclk, scandata, scanwrite, scanread, scanclkena, configupdate},
                 6'b0);
        check_eq("rst_scanaclr", scanaclr, 1'b1);
        check_eq("rst_rd", {host_if.rd_m, host_if.rd_n}, 18'h0);
        repeat (3) @(posedge inclk0);
        #1 areset_n = 1'b1;
        tick();
        check_eq("aclr_hold", scanaclr, 1'b1);
        tick();
        check_eq("aclr_release", scanaclr, 1'b0);

        do_write(9'd16, 9'd16, 0, 1'b0, 1'b1);
        check_eq("wr16_word", {host_if.cfg_m, host_if.cfg_n}, 18'b000010000000010000);
        do_read(9'd16, 9'd16);
        do_read(9'h1A5, 9'h03C);
        do_write(9'h0F3, 9'h10A, 0, 1'b1, 1'b0);
        do_write(9'd16, 9'd16, 1, 1'b0, 1'b0);
        do_write(9'h155, 9'h0AA, 2, 1'b0, 1'b0);
        do_write(9'h001, 9'h100, 0, 1'b0, 1'b0);

        // Abort a write once seven bits have gone out.
        host_if.cfg_m  = 9'h1A5;
        host_if.cfg_n  = 9'h03C;
        host_if.wr_req = 1'b1;
        tick();
        host_if.wr_req = 1'b0;
        falls = 0;
        prev_clk = scanclk;
        for (int i = 0; i < 200 && falls < 7; i++) begin
            tick();
            if (prev_clk && !scanclk) falls++;
            prev_clk = scanclk;
        end
        check_eq("abort_falls", falls, 7);
        areset_n = 1'b0;
        #1;
        check_eq("abort_busy", host_if.busy, 1'b0);
        check_eq("abort_scanclk", scanclk, 1'b0);
        check_eq("abort_scanwrite", scanwrite, 1'b0);
        check_eq("abort_done", host_if.done, 1'b0);
        check_eq("abort_aclr", scanaclr, 1'b1);
        @(posedge inclk0);
        #1 areset_n = 1'b1;
        tick();
        check_eq("abort_aclr_hold", scanaclr, 1'b1);
        check_eq("abort_no_done", host_if.done, 1'b0);
        tick();
        check_eq("abort_aclr_rel", scanaclr, 1'b0);
        exp_rd_m = '0;
        exp_rd_n = '0;
        do_write(9'h1A5, 9'h03C, 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_reconfig_ctrl.md
PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

Interface
REQ-001 The block SHALL have parameter SCAN_LEN, default 18, giving the scan chain length in bits, ordered {M[8:0], N[8:0]} and shifted MSB first.
REQ-002 The block SHALL have parameter CLK_DIV, default 2, giving the scanclk half-period in inclk0 cycles; CLK_DIV >= 1.
REQ-003 The block SHALL have parameter TIMEOUT, default 1024, giving the maximum wait in inclk0 cycles in each wait state.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
- inclk0  in  1  the single clock; all logic on its rising edge.
- areset_n  in  1  asynchronous, active-low reset.
- wr_req  in  1  start a write of cfg_m/cfg_n; sampled in IDLE only.
- rd_req  in  1  start a scan-chain readback; sampled in IDLE only.
- cfg_m  in  9  M counter value to write.
- cfg_n  in  9  N counter value to write.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of each operation.
- error  out  1  valid with done; 1 = timeout.
- rd_m  out  9  M value from the last completed read.
- rd_n  out  9  N value from the last completed read.
- scanclk  out  1  scan clock to the PLL.
- scandata  out  1  serial write data.
- scanwrite  out  1  write-shift enable.
- scanread  out  1  read-shift enable.
- scanclkena  out  1  equals scanwrite OR scanread.
- configupdate  out  1  one-cycle reconfiguration strobe.
- scanaclr  out  1  scan-chain clear.
- scandataout  in  1  serial read data from the PLL.
- scandone  in  1  PLL reconfiguration complete.
- locked  in  1  PLL lock indication.

Function
REQ-005 The FSM SHALL have exactly the states IDLE, SHIFT_WR, UPDATE, WAIT_DONE, WAIT_LOCK and SHIFT_RD.
REQ-006 In IDLE, wr_req=1 SHALL load {cfg_m,cfg_n} into the shift register and enter SHIFT_WR; else rd_req=1 SHALL enter SHIFT_RD.
- Simultaneous wr_req and rd_req: write wins; the read is dropped.
- Requests outside IDLE: ignored, not queued.
REQ-007 The scanclk divider SHALL run only in the SHIFT states.
- scanclk is 0 on state entry and toggles every CLK_DIV cycles.
- One bit per scanclk period (2*CLK_DIV cycles).
- scanclk is 0 on state exit.
REQ-008 In SHIFT_WR, scanwrite SHALL be 1 and scandata SHALL be the shift register MSB.
- scandata is valid before the first scanclk rising edge.
- The shift register advances on each scanclk falling edge.
REQ-009 After SCAN_LEN scanclk rising edges, SHIFT_WR SHALL end with scanclk low and enter UPDATE.
- Shift duration: SCAN_LEN*2*CLK_DIV cycles (72 at defaults).
REQ-010 UPDATE SHALL assert configupdate for exactly one cycle, then enter WAIT_DONE.
REQ-011 WAIT_DONE SHALL advance to WAIT_LOCK when scandone=1; WAIT_LOCK SHALL exit with done=1, error=0 when locked=1.
REQ-012 The timeout counter SHALL clear on entry to each wait state.
- If the awaited input is still 0 after TIMEOUT cycles: return to IDLE with done=1, error=1.
REQ-013 In SHIFT_RD, scanread SHALL be 1 and scandataout SHALL be sampled into the shift register LSB on each scanclk rising edge.
- After SCAN_LEN bits: {rd_m,rd_n} loads, done=1 and error=0 for one cycle, return to IDLE.
REQ-014 done SHALL be a single-cycle pulse asserted in the cycle the FSM returns to IDLE.
- error holds its value until the next done.
REQ-015 rd_m and rd_n SHALL change only on a successful read completion.

Reset
REQ-016 While areset_n=0, every output SHALL be 0 except scanaclr=1; the FSM SHALL be in IDLE and all counters and the shift register SHALL be 0.
REQ-017 scanaclr SHALL remain 1 for the first inclk0 cycle after areset_n deasserts, then 0.
REQ-018 Reset asserted mid-operation SHALL abort it immediately with no done pulse.
- The next request restarts from bit 0.

Verification
REQ-019 Write test: cfg_m=16, cfg_n=16, wr_req for 1 cycle at defaults.
- scandata is 000010000000010000 over 18 scanclk periods (72 cycles).
- configupdate pulses once.
- Model asserts scandone 5 cycles later, then locked 10 cycles after that -> done=1, error=0.
REQ-020 Read test: model drives bits of M=16, N=16 on scandataout -> rd_m=16, rd_n=16, done=1, scanwrite never 1.
REQ-021 Timeout test: scandone held 0 -> done=1, error=1 exactly TIMEOUT cycles after WAIT_DONE entry; same check for locked held 0.
REQ-022 Simultaneous wr_req=rd_req=1 -> write sequence runs; scanread stays 0; rd_m/rd_n unchanged.
REQ-023 Reset after the 7th written bit:
- Immediately: busy=0, scanclk=0, scanwrite=0, no done.
- scanaclr stays 1 for one cycle after release.
- A new wr_req shifts all 18 bits from the MSB.
REQ-024 wr_req while busy -> ignored; exactly one done per accepted request.
